// File: rtl/btn_event.sv
// ============================================================================
// Module   : btn_event
// Purpose  : Press / release / long-press / auto-repeat strobes from a clean button level.
// Option   : define BTN_EVENT_AUTOREPEAT_EN to enable repeat_pulse generation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_event #(
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_dly_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             held_q;
`ifdef BTN_EVENT_AUTOREPEAT_EN
    logic             repeat_q;
`endif

    logic w_rise;
    logic w_fall;

    // btn_dly_q clears in reset, so a level held high across reset is seen as a fresh press.
    assign w_rise = btn_level & ~btn_dly_q;
    assign w_fall = ~btn_level & btn_dly_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            btn_dly_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BTN_EVENT_AUTOREPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            btn_dly_q <= btn_level;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
`ifdef BTN_EVENT_AUTOREPEAT_EN
            repeat_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (w_rise) begin
                        state_q <= PRESS;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end
                end
                PRESS: begin
                    // Release is tested first so it wins over a coincident long threshold.
                    if (w_fall) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_q == c_LONG_LAST) begin
                        state_q <= LONG;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + c_ONE;
                    end
                end
                LONG: begin
                    if (w_fall) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
`ifdef BTN_EVENT_AUTOREPEAT_EN
                    end else if (cnt_q == c_REPEAT_LAST) begin
                        cnt_q    <= '0;
                        repeat_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + c_ONE;
                    end
`else
                    end else if (cnt_q != c_REPEAT_LAST) begin
                        // Saturate so a long hold can never wrap the counter.
                        cnt_q <= cnt_q + c_ONE;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign held          = held_q;
`ifdef BTN_EVENT_AUTOREPEAT_EN
    assign repeat_pulse  = repeat_q;
`else
    assign repeat_pulse  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_btn_event.sv
// ============================================================================
// Module   : tb_btn_event
// Purpose  : Directed vector bench for btn_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_event;

    localparam int c_LONG   = 8;
    localparam int c_REPEAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_level = 1'b0;
    logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;

    int errors = 0;
    int checks = 0;

    btn_event #(
        .LONG_CYCLES   (c_LONG),
        .REPEAT_CYCLES (c_REPEAT),
        .CNT_W         (16)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    // Expected bits are {press, release, long, repeat, held} after the edge.
    typedef struct {
        logic       rst_v;
        logic       btn_v;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic b, input logic [4:0] e, input string n);
        vec_t v;
        v.rst_v = r;
        v.btn_v = b;
        v.exp   = e;
        v.name  = n;
        vecs.push_back(v);
    endtask

    task automatic step_check(input logic r, input logic b, input logic [4:0] e, input string n);
        logic [4:0] got;
        @(negedge clk);
        rst_n     = r;
        btn_level = b;
        @(posedge clk);
        #1;
        got = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got p/r/l/rp/h=%b required %b", n, got, e);
        end
        checks++;
        if ($countones(got[4:1]) > 1) begin
            errors++;
            $display("FAIL %s_exclusive: got strobes=%b required at most one high", n, got[4:1]);
        end
    endtask

    // Hold the button n cycles; offset j is the cycle after the j-th sampled edge.
    task automatic run_hold(input int n, input int long_at, input int rep1, input int rep2,
                            input string n_s);
        logic [4:0] e;
        for (int j = 1; j <= n + 2; j++) begin
            e[4] = (j == 1);
            e[3] = (j == n + 1);
            e[2] = (j == long_at);
            e[1] = (j == rep1) || (j == rep2);
            e[0] = (j <= n);
            step_check(1'b1, (j <= n), e, $sformatf("%s_c%0d", n_s, j));
        end
    endtask

    initial begin
        // Reset with button low, then idle
        for (int i = 0; i < 3; i++) add_vec(1'b0, 1'b0, 5'b00000, "reset_hold");
        for (int i = 0; i < 5; i++) add_vec(1'b1, 1'b0, 5'b00000, "post_reset_idle");
        // Five-cycle press
        add_vec(1'b1, 1'b1, 5'b10001, "p5_press");
        for (int i = 0; i < 4; i++) add_vec(1'b1, 1'b1, 5'b00001, "p5_held");
        add_vec(1'b1, 1'b0, 5'b01000, "p5_release");
        add_vec(1'b1, 1'b0, 5'b00000, "p5_idle");
        // Single-cycle press
        add_vec(1'b1, 1'b1, 5'b10001, "p1_press");
        add_vec(1'b1, 1'b0, 5'b01000, "p1_release");
        add_vec(1'b1, 1'b0, 5'b00000, "p1_idle");
        // Button already high when reset releases
        add_vec(1'b0, 1'b1, 5'b00000, "rst_btn_high");
        add_vec(1'b1, 1'b1, 5'b10001, "rst_rel_press");
        add_vec(1'b1, 1'b1, 5'b00001, "rst_rel_held");
        add_vec(1'b1, 1'b0, 5'b01000, "rst_rel_release");
        add_vec(1'b1, 1'b0, 5'b00000, "rst_rel_idle");

        foreach (vecs[i]) step_check(vecs[i].rst_v, vecs[i].btn_v, vecs[i].exp, vecs[i].name);

`ifdef BTN_EVENT_AUTOREPEAT_EN
        run_hold(20, 9, 13, 17, "hold20");
`else
        run_hold(20, 9, 0, 0, "hold20");
`endif
        // Fall coincides with the long threshold: release only
        run_hold(8, 0, 0, 0, "hold8");
        // One cycle past the threshold: long then release
        run_hold(9, 9, 0, 0, "hold9");

        // Reset mid-press aborts silently, then a fresh press follows
        step_check(1'b1, 1'b1, 5'b10001, "abort_press");
        for (int j = 2; j <= 10; j++)
            step_check(1'b1, 1'b1, (j == 9) ? 5'b00101 : 5'b00001, $sformatf("abort_hold_c%0d", j));
        step_check(1'b0, 1'b1, 5'b00000, "abort_reset");
        step_check(1'b1, 1'b1, 5'b10001, "abort_repress");
        step_check(1'b1, 1'b0, 5'b01000, "abort_release");
        step_check(1'b1, 1'b0, 5'b00000, "abort_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
